// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ADD/SUB/SLT/AND/OR plus a multi-cycle restoring signed divider.
// Optional unsigned divide (funct 011011) is enabled by defining ALU_SEQ_DIVU_EN.
module alu_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       alu_op_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             zero_o,
    output logic [3:0]       alu_control_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic             illegal_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlSlt = 4'b0111;
    localparam logic [3:0] CtrlDiv = 4'b1010;
    localparam logic [3:0] CtrlAnd = 4'b0000;
    localparam logic [3:0] CtrlOr  = 4'b0001;
    localparam logic [3:0] CtrlIll = 4'b1111;
`ifdef ALU_SEQ_DIVU_EN
    localparam logic [3:0] CtrlDivu = 4'b1011;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StDivRun,
        StDivFix
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  prem_q;
    logic [WIDTH-1:0]  dvsr_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  remainder_q;
    logic              zero_q;
    logic [3:0]        ctrl_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;
    logic              ill_q;

    logic [3:0]        dec_ctrl;
    logic              dec_div;
    logic              dec_signed;

    always_comb begin
        dec_ctrl   = CtrlIll;
        dec_div    = 1'b0;
        dec_signed = 1'b1;
        unique case (alu_op_i)
            2'b00: dec_ctrl = CtrlAdd;
            2'b01: dec_ctrl = CtrlSub;
            2'b10: begin
                case (funct_i)
                    6'b100000: dec_ctrl = CtrlAdd;
                    6'b100010: dec_ctrl = CtrlSub;
                    6'b101010: dec_ctrl = CtrlSlt;
                    6'b100100: dec_ctrl = CtrlAnd;
                    6'b100101: dec_ctrl = CtrlOr;
                    6'b011010: begin
                        dec_ctrl = CtrlDiv;
                        dec_div  = 1'b1;
                    end
`ifdef ALU_SEQ_DIVU_EN
                    6'b011011: begin
                        dec_ctrl   = CtrlDivu;
                        dec_div    = 1'b1;
                        dec_signed = 1'b0;
                    end
`endif
                    default: dec_ctrl = CtrlIll;
                endcase
            end
            default: dec_ctrl = CtrlIll;
        endcase
    end

    logic [WIDTH-1:0] imm_res;
    logic [WIDTH-1:0] imm_rem;

    // The divide entry here only matters for b==0, the one divide that completes in one cycle.
    always_comb begin
        imm_res = '0;
        imm_rem = '0;
        case (dec_ctrl)
            CtrlAdd: imm_res = a_i + b_i;
            CtrlSub: imm_res = a_i - b_i;
            CtrlSlt: imm_res = WIDTH'($signed(a_i) < $signed(b_i));
            CtrlAnd: imm_res = a_i & b_i;
            CtrlOr:  imm_res = a_i | b_i;
            default: begin
                if (dec_div) begin
                    imm_res = '1;
                    imm_rem = a_i;
                end
            end
        endcase
    end

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_neg = dec_signed & a_i[WIDTH-1];
        b_neg = dec_signed & b_i[WIDTH-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    logic [WIDTH:0]   shift_w;
    logic [WIDTH:0]   trial_w;
    logic [WIDTH-1:0] prem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    // One restoring step: a borrow out of the trial subtraction means the divisor did not fit.
    always_comb begin
        shift_w = {prem_q, quo_q[WIDTH-1]};
        trial_w = shift_w - {1'b0, dvsr_q};
        if (!trial_w[WIDTH]) begin
            prem_d = trial_w[WIDTH-1:0];
            quo_d  = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            prem_d = shift_w[WIDTH-1:0];
            quo_d  = {quo_q[WIDTH-2:0], 1'b0};
        end
        fix_quo = q_neg_q ? -quo_q : quo_q;
        fix_rem = r_neg_q ? -prem_q : prem_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            prem_q      <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            zero_q      <= 1'b1;
            ctrl_q      <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        ctrl_q <= dec_ctrl;
                        ill_q  <= (dec_ctrl == CtrlIll);
                        dbz_q  <= 1'b0;
                        if (dec_div && (b_i != '0)) begin
                            state_q <= StDivRun;
                            busy_q  <= 1'b1;
                            cnt_q   <= CntW'(WIDTH);
                            prem_q  <= '0;
                            quo_q   <= a_mag;
                            dvsr_q  <= b_mag;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                        end else begin
                            result_q    <= imm_res;
                            remainder_q <= imm_rem;
                            zero_q      <= (imm_res == '0);
                            dbz_q       <= dec_div;
                            done_q      <= 1'b1;
                        end
                    end
                end
                StDivRun: begin
                    prem_q <= prem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StDivFix;
                    end
                end
                StDivFix: begin
                    result_q    <= fix_quo;
                    remainder_q <= fix_rem;
                    zero_q      <= (fix_quo == '0);
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o      = result_q;
    assign remainder_o   = remainder_q;
    assign zero_o        = zero_q;
    assign alu_control_o = ctrl_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign illegal_o     = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=32): directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_seq_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         zero;
    logic [3:0]   alu_control;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         illegal;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] prev_result = '0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .alu_op_i     (alu_op),
        .funct_i      (funct),
        .a_i          (a),
        .b_i          (b),
        .result_o     (result),
        .remainder_o  (remainder),
        .zero_o       (zero),
        .alu_control_o(alu_control),
        .busy_o       (busy),
        .done_o       (done),
        .div_by_zero_o(div_by_zero),
        .illegal_o    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference behaviour from plain arithmetic; iter marks divides that take the long path.
    function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [W-1:0] rem,
                                  output logic [3:0] ctrl, output bit dbz, output bit ill,
                                  output bit iter);
        longint sx;
        longint sy;
        longint q;
        longint m;
        bit     is_div;
        bit     is_divu;
        r = '0; rem = '0; ctrl = 4'b1111; dbz = 0; ill = 0; iter = 0;
        is_div = 0; is_divu = 0;
        if (op == 2'b00) begin
            r = x + y; ctrl = 4'b0010;
        end else if (op == 2'b01) begin
            r = x - y; ctrl = 4'b0110;
        end else if (op == 2'b10 && f == 6'h20) begin
            r = x + y; ctrl = 4'b0010;
        end else if (op == 2'b10 && f == 6'h22) begin
            r = x - y; ctrl = 4'b0110;
        end else if (op == 2'b10 && f == 6'h2a) begin
            r = ($signed(x) < $signed(y)) ? 1 : 0; ctrl = 4'b0111;
        end else if (op == 2'b10 && f == 6'h24) begin
            r = x & y; ctrl = 4'b0000;
        end else if (op == 2'b10 && f == 6'h25) begin
            r = x | y; ctrl = 4'b0001;
        end else if (op == 2'b10 && f == 6'h1a) begin
            is_div = 1; ctrl = 4'b1010;
`ifdef ALU_SEQ_DIVU_EN
        end else if (op == 2'b10 && f == 6'h1b) begin
            is_divu = 1; ctrl = 4'b1011;
`endif
        end else begin
            ill = 1;
        end
        if (is_div || is_divu) begin
            if (y == 0) begin
                r = '1; rem = x; dbz = 1;
            end else begin
                iter = 1;
                if (is_div) begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q = sx / sy;
                    m = sx % sy;
                    r = q[W-1:0];
                    rem = m[W-1:0];
                end else begin
                    r = x / y;
                    rem = x % y;
                end
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic [W-1:0] erem;
        logic [3:0]   ec;
        bit           edbz, eill, eiter;
        int           cyc, busy_cyc, changes;
        bit           got_done;
        model(op, f, x, y, er, erem, ec, edbz, eill, eiter);
        @(negedge clk);
        alu_op = op; funct = f; a = x; b = y; start = 1'b1;
        @(posedge clk);
        cyc = 0; busy_cyc = 0; changes = 0; got_done = 0;
        while (!got_done && cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            a = $urandom;
            b = $urandom;
            cyc++;
            if (busy) begin
                busy_cyc++;
                if (result !== prev_result) changes++;
                if (cyc == 5) begin
                    start = 1'b1;
                    alu_op = 2'b00;
                end
            end
            if (done) got_done = 1;
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, 64'(cyc), eiter ? 64'(W + 2) : 64'd1);
        check_eq({tag, ".busy_cycles"}, 64'(busy_cyc), eiter ? 64'(W + 1) : 64'd0);
        if (eiter) check_eq({tag, ".stable_while_busy"}, 64'(changes), 64'd0);
        check_eq({tag, ".result"}, 64'(result), 64'(er));
        check_eq({tag, ".remainder"}, 64'(remainder), 64'(erem));
        check_eq({tag, ".zero"}, 64'(zero), 64'(er == '0));
        check_eq({tag, ".alu_control"}, 64'(alu_control), 64'(ec));
        check_eq({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(edbz));
        check_eq({tag, ".illegal"}, 64'(illegal), 64'(eill));
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, ".hold"}, 64'(result), 64'(er));
        prev_result = er;
    endtask

    logic [5:0] functs [8];
    int         ndone;

    initial begin
        functs = '{6'h20, 6'h22, 6'h2a, 6'h24, 6'h25, 6'h1a, 6'h1b, 6'h00};
        reset = 1'b1; start = 1'b0; alu_op = '0; funct = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.result", 64'(result), 64'd0);
        check_eq("rst.remainder", 64'(remainder), 64'd0);
        check_eq("rst.zero", 64'(zero), 64'd1);
        check_eq("rst.alu_control", 64'(alu_control), 64'd0);
        check_eq("rst.busy_done", 64'({busy, done}), 64'd0);
        check_eq("rst.flags", 64'({div_by_zero, illegal}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_op("first_add", 2'b00, 6'h00, 32'd10, 32'd20);
        run_op("slt", 2'b10, 6'h2a, 32'hFFFFFFFF, 32'd1);
        run_op("div_m7_2", 2'b10, 6'h1a, 32'hFFFFFFF9, 32'd2);

        @(negedge clk);
        alu_op = 2'b10; funct = 6'h1a; a = 32'd100; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("abort.busy", 64'(busy), 64'd0);
        check_eq("abort.done", 64'(done), 64'd0);
        check_eq("abort.result", 64'(result), 64'd0);
        check_eq("abort.zero", 64'(zero), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("abort.no_done", 64'(ndone), 64'd0);
        prev_result = '0;

        run_op("div_5_0", 2'b10, 6'h1a, 32'd5, 32'd0);
        run_op("div_minneg", 2'b10, 6'h1a, 32'h80000000, 32'hFFFFFFFF);
        run_op("funct_1b", 2'b10, 6'h1b, 32'd7, 32'd2);
        run_op("illegal_op", 2'b11, 6'h20, 32'd7, 32'd2);
        run_op("and", 2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF);

        @(negedge clk);
        alu_op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        check_eq("b2b.done1", 64'(done), 64'd1);
        check_eq("b2b.add", 64'(result), 64'd7);
        alu_op = 2'b01; a = 32'd4; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b.done2", 64'(done), 64'd1);
        check_eq("b2b.sub", 64'(result), 64'd0);
        check_eq("b2b.zero", 64'(zero), 64'd1);
        check_eq("b2b.ctrl", 64'(alu_control), 64'b0110);
        @(negedge clk);
        check_eq("b2b.done_end", 64'(done), 64'd0);
        prev_result = '0;

        for (int i = 0; i < 30; i++) begin
            logic [1:0]   op;
            logic [5:0]   f;
            logic [W-1:0] x, y;
            int           sel, bm;
            sel = $urandom_range(0, 9);
            f = functs[$urandom_range(0, 7)];
            if (f == 6'h00) f = 6'($urandom);
            op = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            bm = $urandom_range(0, 5);
            y = (bm == 0) ? 32'd0 : (bm == 1) ? 32'($urandom_range(1, 15)) :
                (bm == 2) ? 32'hFFFFFFFF : $urandom;
            run_op("rand", op, f, x, y);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; accepted only on a rising edge where busy=0.
REQ-005 alu_op  input  2  00=ADD (lw/sw), 01=SUB (beq), 10=R-type (decode funct), 11=illegal.
REQ-006 funct  input  6  R-type function field, sampled with start.
REQ-007 a, b  input  WIDTH each  operands, sampled with start; ignored otherwise.
REQ-008 result  output  WIDTH  registered result / quotient.
REQ-009 remainder  output  WIDTH  registered remainder; 0 for non-divide ops.
REQ-010 zero  output  1  registered, result==0.
REQ-011 alu_control  output  4  registered decoded op: 0010 ADD, 0110 SUB, 0111 SLT, 1010 DIV, 1011 DIVU, 0000 AND, 0001 OR, 1111 illegal.
REQ-012 busy  output  1  high while a divide iterates; start ignored.
REQ-013 done  output  1  one-cycle pulse, outputs valid from this cycle until next accepted start.
REQ-014 div_by_zero, illegal  output  1 each  status flags, valid with done, held until next accepted start.

Function
REQ-015 States IDLE, DIV_RUN, DIV_FIX; done is a registered pulse, not a state.
REQ-016 Funct decode: 100000 ADD, 100010 SUB, 101010 SLT (signed, result 1/0), 100100 AND, 100101 OR, 011010 DIV (signed); any other funct -> illegal.
REQ-017 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-018 Non-divide op (incl. illegal) accepted in IDLE: result, zero, alu_control, flags registered on that edge; done=1 the following cycle; state stays IDLE; busy never asserts.
REQ-019 Illegal op: result=0, remainder=0, zero=1, illegal=1, alu_control=1111.
REQ-020 DIV with b!=0: IDLE->DIV_RUN, busy=1; restoring divide on operand magnitudes, one quotient bit per cycle, internal counter WIDTH..1.
REQ-021 DIV_RUN->DIV_FIX when counter reaches 1; DIV_FIX applies signs (quotient negated if signs differ, remainder takes sign of a), writes result/remainder/zero, ->IDLE, busy=0, done=1 next cycle.
REQ-022 Divide latency: start edge to done = WIDTH+2 cycles; busy high exactly WIDTH+1 cycles.
REQ-023 DIV with b==0: no iteration; result=all ones, remainder=a, div_by_zero=1, done after 1 cycle like REQ-018.
REQ-024 DIV of most-negative by -1: result=most-negative (wrap), remainder=0, no flag.
REQ-025 start while busy=1: ignored, no effect on state, operands, or outputs.
REQ-026 start in the same cycle done=1 with busy=0: accepted normally (back-to-back throughput one op per cycle for non-divide ops).
REQ-027 result, remainder, zero, flags change only on an accepted start edge (non-divide) or DIV_FIX edge.

Reset
REQ-028 reset=1 immediately forces IDLE, counter 0, result=0, remainder=0, zero=1, alu_control=0000, busy=0, done=0, div_by_zero=0, illegal=0.
REQ-029 reset during DIV_RUN/DIV_FIX aborts the divide; no done pulse is produced for it.
REQ-030 First start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro ALU_SEQ_DIVU_EN: when defined, funct 011011 decodes as DIVU (unsigned divide, alu_control 1011, same latency and div-by-zero rules, DIV_FIX applies no sign correction).
REQ-032 Without ALU_SEQ_DIVU_EN, funct 011011 is illegal per REQ-019 and code 1011 never appears.

Verification (WIDTH=32)
REQ-033 reset pulse mid-divide -> next cycle busy=0, done=0, result=0, zero=1; no later done.
REQ-034 alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> done next cycle, result=1, alu_control=0111, busy never high.
REQ-035 DIV a=-7, b=2 -> busy 33 cycles, done 34 cycles after start, result=-3 (0xFFFFFFFD), remainder=-1; start pulsed during busy ignored.
REQ-036 DIV a=5, b=0 -> done next cycle, result=0xFFFFFFFF, remainder=5, div_by_zero=1; DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000, remainder=0.
REQ-037 funct=011011, a=7, b=2 -> with macro: result=3, remainder=1, alu_control=1011; without: illegal=1, result=0, zero=1.
REQ-038 Back-to-back ADD 3+4 then SUB 4-4 on consecutive cycles -> done two consecutive cycles, results 7 then 0 with zero=1.
